// File: rtl/pattern_player.sv
// pattern_player: plays a latched pattern as one-hot LED flashes with programmable on-time and gap
module pattern_player #(
   parameter int SYM_W      = 3,
   parameter int MAX_LEN    = 25,
   parameter int ON_CYCLES  = 4,
   parameter int OFF_CYCLES = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     abort,
   input  logic [SYM_W*MAX_LEN-1:0] pattern,
   input  logic [4:0]               length,
   output logic [2**SYM_W-1:0]      led,
   output logic                     busy,
   output logic                     done,
   output logic [4:0]               cur_idx
);
   localparam int PW = SYM_W * MAX_LEN;
   localparam int LW = 2 ** SYM_W;
   localparam int TW = $clog2(ON_CYCLES > OFF_CYCLES ? ON_CYCLES : OFF_CYCLES) + 1;
   typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP, S_DONE} state_t;
   state_t state, state_d;
   logic [TW-1:0] timer, timer_d;
   logic [PW-1:0] pat, pat_d;
   logic [4:0] len, len_d, idx_d;
   logic [LW-1:0] led_d;
   logic [SYM_W-1:0] sym;
   logic busy_d, done_d, go, load, last_on, last_off, last_idx;
   assign go       = start && !abort;
   assign load     = state == S_IDLE && go;
   assign last_on  = timer == TW'(ON_CYCLES - 1);
   assign last_off = timer == TW'(OFF_CYCLES - 1);
   assign last_idx = cur_idx == len - 5'd1;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         timer   <= '0;
         pat     <= '0;
         len     <= '0;
         cur_idx <= '0;
         led     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_d;
         timer   <= timer_d;
         pat     <= pat_d;
         len     <= len_d;
         cur_idx <= idx_d;
         led     <= led_d;
         busy    <= busy_d;
         done    <= done_d;
      end
   end
   always_comb begin
      state_d = state;
      case (state)
         S_IDLE:  state_d = go ? (length == 5'd0 ? S_DONE : S_ON) : S_IDLE;
         S_ON:    state_d = abort ? S_IDLE : last_on ? S_GAP : S_ON;
         S_GAP:   state_d = abort ? S_IDLE : !last_off ? S_GAP : last_idx ? S_DONE : S_ON;
         default: state_d = S_IDLE;
      endcase
   end
   // the LED for the upcoming entry is taken from the value being latched this edge
   always_comb begin
      pat_d   = load ? pattern : pat;
      len_d   = load ? (length > 5'(MAX_LEN) ? 5'(MAX_LEN) : length) : len;
      idx_d   = (load && length != 5'd0) ? 5'd0 :
                (state == S_GAP && state_d == S_ON) ? cur_idx + 5'd1 : cur_idx;
      timer_d = (state_d == state && (state == S_ON || state == S_GAP)) ? timer + TW'(1) : '0;
      sym     = SYM_W'(pat_d >> (idx_d * SYM_W));
      led_d   = state_d == S_ON ? LW'(1) << sym : '0;
      busy_d  = state_d == S_ON || state_d == S_GAP;
      done_d  = state_d == S_DONE;
   end
endmodule

// File: tb/tb_pattern_player.sv
// tb_pattern_player: table vectors, directed corner sequences and randomized playbacks against a cycle model
module tb_pattern_player;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
   logic [74:0] pattern = '0;
   logic [4:0] length = '0;
   logic [7:0] led;
   logic busy, done;
   logic [4:0] cur_idx;
   int errors = 0, checks = 0, last_idx = 0, fl, bc;
   typedef struct {int first; int last; logic [7:0] led; logic busy; logic done;} vec_t;
   vec_t basic [8];
   localparam logic [74:0] BASIC = 75'b000_101_011;

   pattern_player dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pattern(pattern),
      .length(length), .led(led), .busy(busy), .done(done), .cur_idx(cur_idx)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got=%0h want=%0h", name, c, act, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".led"}, -1, 32'(led), 0);
      chk({tag, ".busy"}, -1, 32'(busy), 0);
      chk({tag, ".done"}, -1, 32'(done), 0);
   endtask

   // Expected LED c edges after the start edge: 6-cycle slots, lit for the first 4
   function automatic logic [7:0] m_led(input logic [74:0] p, input int eff, input int c);
      logic [74:0] s;
      if (c >= eff * 6 || c % 6 >= 4) return 8'h00;
      s = p >> (3 * (c / 6));
      return 8'(1) << s[2:0];
   endfunction

   task automatic play(input logic [74:0] p, input int len, input int restart_at, input int chg_at,
                       input int abort_at, input int rst_at, input string tag,
                       output int flashes, output int busy_cnt);
      int eff;
      logic [7:0] prev;
      eff = len > 25 ? 25 : len;
      flashes = 0;
      busy_cnt = 0;
      prev = 8'h00;
      pattern = p;
      length = 5'(len);
      start = 1'b1;
      for (int c = 0; c <= eff * 6 + 1; c++) begin
         step();
         if (c == abort_at || c == rst_at) begin
            chk({tag, ".stop_led"}, c, 32'(led), 0);
            chk({tag, ".stop_busy"}, c, 32'(busy), 0);
            chk({tag, ".stop_done"}, c, 32'(done), 0);
            last_idx = c == abort_at ? (c - 1) / 6 : 0;
            chk({tag, ".stop_idx"}, c, 32'(cur_idx), 32'(last_idx));
            abort = 1'b0;
            rst_n = 1'b1;
            start = 1'b0;
            return;
         end
         if (led != 8'h00 && prev == 8'h00) flashes++;
         if (busy) busy_cnt++;
         prev = led;
         chk({tag, ".led"}, c, 32'(led), 32'(m_led(p, eff, c)));
         chk({tag, ".busy"}, c, 32'(busy), 32'(c < eff * 6));
         chk({tag, ".done"}, c, 32'(done), 32'(c == eff * 6));
         chk({tag, ".idx"}, c, 32'(cur_idx), 32'(eff == 0 ? last_idx : c < eff * 6 ? c / 6 : eff - 1));
         start = (c + 1 == restart_at);
         if (c + 1 == chg_at) pattern = '1;
         abort = (c + 1 == abort_at);
         rst_n = !(c + 1 == rst_at);
      end
      if (eff > 0) last_idx = eff - 1;
      start = 1'b0;
   endtask

   initial begin
      basic[0] = '{0, 3, 8'h08, 1'b1, 1'b0};
      basic[1] = '{4, 5, 8'h00, 1'b1, 1'b0};
      basic[2] = '{6, 9, 8'h20, 1'b1, 1'b0};
      basic[3] = '{10, 11, 8'h00, 1'b1, 1'b0};
      basic[4] = '{12, 15, 8'h01, 1'b1, 1'b0};
      basic[5] = '{16, 17, 8'h00, 1'b1, 1'b0};
      basic[6] = '{18, 18, 8'h00, 1'b0, 1'b1};
      basic[7] = '{19, 20, 8'h00, 1'b0, 1'b0};

      start = 1'b1;
      pattern = BASIC;
      length = 5'd3;
      step();
      step();
      chk_idle("reset");
      chk("reset.idx", -1, 32'(cur_idx), 0);
      rst_n = 1'b1;
      start = 1'b0;
      step();
      chk_idle("post_reset");

      start = 1'b1;
      for (int c = 0; c <= 20; c++) begin
         step();
         start = 1'b0;
         for (int r = 0; r < 8; r++)
            if (c >= basic[r].first && c <= basic[r].last) begin
               chk("table.led", c, 32'(led), 32'(basic[r].led));
               chk("table.busy", c, 32'(busy), 32'(basic[r].busy));
               chk("table.done", c, 32'(done), 32'(basic[r].done));
            end
      end
      last_idx = 2;

      play(BASIC, 3, 7, 8, -1, -1, "latch", fl, bc);
      play(BASIC, 0, -1, -1, -1, -1, "len0", fl, bc);
      chk("len0.busy_cnt", -1, 32'(bc), 0);
      step();
      chk_idle("len0_after");

      play('1, 31, -1, -1, -1, -1, "clamp", fl, bc);
      chk("clamp.flashes", -1, 32'(fl), 25);
      chk("clamp.busy_cnt", -1, 32'(bc), 150);

      play(BASIC, 3, -1, -1, 8, -1, "abort", fl, bc);
      step();
      chk_idle("abort_after");
      play(BASIC, 3, -1, -1, -1, -1, "replay", fl, bc);

      play(BASIC, 3, -1, -1, -1, 13, "midrst", fl, bc);
      step();
      chk_idle("midrst_after");
      play(BASIC, 3, -1, -1, -1, -1, "after_rst", fl, bc);

      for (int i = 0; i < 10; i++) begin
         logic [74:0] rp;
         int len, eff, ra, ca, ab;
         rp = {11'($urandom), $urandom, $urandom};
         len = int'($urandom_range(0, 31));
         eff = len > 25 ? 25 : len;
         ra = (eff > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, eff * 6)) : -1;
         ca = (eff > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, eff * 6)) : -1;
         ab = (eff > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, eff * 6)) : -1;
         play(rp, len, ra, ca, ab, -1, "rand", fl, bc);
         if (ab >= 0) begin
            step();
            chk_idle("rand_abort_after");
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
